// File: rtl/shift_unloader_pkg.sv
// shift_unloader shared types and helpers.
// Common to the unloader top, its beat counter and its bus interface.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SIZE  = 8;

  // Beat counter width; a counter is never narrower than one bit.
  function automatic int cnt_w(input int size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/shift_unloader_if.sv
// shift_unloader load/unload bus.
// master drives vectors in and sinks beats; slave is the unloader.
interface shift_unloader_if #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 8
);

  logic                  load_valid;
  logic                  load_ready;
  logic [WIDTH*SIZE-1:0] load_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      data_out;
  logic                  out_last;
  logic                  busy;

  modport master (
    output load_valid,
    output load_data,
    output out_ready,
    input  load_ready,
    input  out_valid,
    input  data_out,
    input  out_last,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  out_ready,
    output load_ready,
    output out_valid,
    output data_out,
    output out_last,
    output busy
  );

endinterface

// File: rtl/shift_unloader_beat_counter.sv
// Loadable down-counter with zero flag.
// Tracks remaining beats minus one for the unloader.
module shift_beat_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] init,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= init;
    end else if (dec && !zero) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/shift_unloader.sv
// Parallel-load, word-serial shift-out register (MSB slot first).
// SHIFT_UNLOADER_B2B_EN: reload on the last beat for zero-bubble vectors.
module shift_unloader
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SIZE  = DEF_SIZE
) (
  input logic            clk,
  input logic            rst,
  shift_unloader_if.slave bus
);

  localparam int CNT_W = cnt_w(SIZE);
  localparam int VW    = WIDTH * SIZE;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [VW-1:0]    buffer;
  logic [CNT_W-1:0] count;
  logic             count_zero;
  logic             beat;
  logic             load_fire;

  assign beat      = bus.out_valid & bus.out_ready;
  assign load_fire = bus.load_valid & bus.load_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: load starts a vector, last accepted beat ends it.
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (bus.load_valid) begin
          state_nxt = SHIFT;
        end
      end
      (state == SHIFT): begin
        if (beat && count_zero) begin
          state_nxt = load_fire ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; data is the buffer top, zero once drained.
  always_comb begin
    bus.out_valid = (state == SHIFT);
    bus.busy      = (state == SHIFT);
    bus.out_last  = (state == SHIFT) & count_zero;
    bus.data_out  = buffer[VW-1 -: WIDTH];
`ifdef SHIFT_UNLOADER_B2B_EN
    bus.load_ready = (state == IDLE) |
                     (bus.out_ready & count_zero);
`else
    bus.load_ready = (state == IDLE);
`endif
  end

  // Buffer: capture on load, shift zeros in from the LSB on each beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer <= '0;
    end else if (load_fire) begin
      buffer <= bus.load_data;
    end else if (beat) begin
      buffer <= buffer << WIDTH;
    end
  end

  shift_beat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (load_fire),
    .init  (LAST_IDX),
    .dec   (beat),
    .count (count),
    .zero  (count_zero)
  );

endmodule

// File: tb/tb_shift_unloader.sv
// Randomized self-checking bench for shift_unloader.
// Beat-queue scoreboard plus a shift_register-style loopback receiver.
module tb_shift_unloader;

  localparam int W  = 8;
  localparam int S  = 8;
  localparam int VW = W * S;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int fails  = 0;

  shift_unloader_if #(.WIDTH(W), .SIZE(S)) bus ();

  shift_unloader #(.WIDTH(W), .SIZE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // out_ready driver: 0 always high, 1 fixed pattern, 2 random.
  int rdy_mode = 0;
  int pat_i    = 0;
  bit pat [6]  = '{1, 0, 0, 1, 0, 1};

  initial begin
    bus.out_ready  = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.out_ready = 1'b1;
      1: begin
        bus.out_ready = pat[pat_i];
        pat_i = (pat_i + 1) % 6;
      end
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: expected beats and reconstructed vectors.
  beat_t         exp_q [$];
  logic [VW-1:0] vec_q [$];
  logic [VW-1:0] acc       = '0;
  bit            prev_rst  = 0;
  bit            prev_load = 0;
  bit            prev_last = 0;
  bit            prev_stall = 0;
  logic [W-1:0]  prev_data = '0;
  logic          prev_olast = 1'b0;

  always @(negedge clk) begin
    logic  lr_exp;
    bit    beat;
    bit    lf;
    beat_t e;
    if (prev_rst) begin
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.data_out, 0);
      check("rst_last", bus.out_last, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.load_ready, 1);
    end else begin
      check("busy", bus.busy, bus.out_valid);
`ifdef SHIFT_UNLOADER_B2B_EN
      lr_exp = !bus.out_valid || (bus.out_ready && (exp_q.size() == 1));
`else
      lr_exp = !bus.out_valid;
`endif
      check("load_ready", bus.load_ready, lr_exp);
      if (!bus.out_valid) check("idle_zero", bus.data_out, 0);
      if (prev_load) check("latency", bus.out_valid, 1);
      else if (prev_last) check("bubble", bus.out_valid, 0);
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.data_out, prev_data);
        check("hold_last", bus.out_last, prev_olast);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious", 1, 0);
        end else begin
          e = exp_q[0];
          check("data", bus.data_out, e.d);
          check("last", bus.out_last, e.l);
        end
      end
    end
    if (rst) begin
      exp_q.delete();
      vec_q.delete();
      acc        = '0;
      prev_rst   = 1;
      prev_load  = 0;
      prev_last  = 0;
      prev_stall = 0;
    end else begin
      prev_rst = 0;
      beat = bus.out_valid && bus.out_ready;
      lf   = bus.load_valid && bus.load_ready;
      prev_last = 0;
      if (beat && exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        acc = {acc[VW-W-1:0], bus.data_out};
        if (e.l) begin
          prev_last = 1;
          check("loopback", acc, vec_q.pop_front());
        end
      end
      if (lf) begin
        for (int k = S - 1; k >= 0; k--) begin
          e.d = bus.load_data[k*W +: W];
          e.l = (k == 0);
          exp_q.push_back(e);
        end
        vec_q.push_back(bus.load_data);
      end
      prev_load  = lf;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.data_out;
      prev_olast = bus.out_last;
    end
  end

  task automatic load_vec(input logic [VW-1:0] v);
    bit done = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = v;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.load_ready && !rst) done = 1;
      @(posedge clk);
      #1;
    end
    bus.load_valid = 1'b0;
    if (!done) check("load_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1;
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] seq_v;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed order, last flag and busy fall.
    rdy_mode = 0;
    seq_v = 64'h0123456789ABCDEF;
    load_vec(seq_v);
    for (int i = 0; i < S; i++) begin
      @(negedge clk);
      check("seq_data", bus.data_out, seq_v[(S-1-i)*W +: W]);
      check("seq_last", bus.out_last, (i == S - 1));
    end
    @(negedge clk);
    check("busy_fall", bus.busy, 0);
    @(posedge clk);
    #1;

    // Backpressure pattern.
    rdy_mode = 1;
    pat_i    = 0;
    load_vec(64'hFEDCBA9876543210);
    wait_idle();

    // load_valid held during SHIFT must be ignored until idle.
    rdy_mode = 0;
    load_vec({8{8'hAA}});
    load_vec({8{8'h11}});
    wait_idle();

    // Reset after the third beat, then restart.
    load_vec({$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_vec(64'h8877665544332211);
    wait_idle();

    // Random loopback with random backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 10; n++) begin
      v = {$urandom, $urandom};
      load_vec(v);
    end
    wait_idle();

`ifdef SHIFT_UNLOADER_B2B_EN
    // Two vectors back to back: 16 valid beats, no gap.
    rdy_mode = 0;
    load_vec(64'h0102030405060708);
    fork
      load_vec(64'h1112131415161718);
      begin
        for (int i = 0; i < 2 * S; i++) begin
          @(negedge clk);
          check("b2b_valid", bus.out_valid, 1);
          check("b2b_last", bus.out_last, (i == S - 1) || (i == 2 * S - 1));
        end
      end
    join
    wait_idle();
`endif

    repeat (3) @(posedge clk);
    check("drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/shift_unloader.md
Name: shift_unloader

Overview:
- Parallel-load, word-serial shift-out register. It is the transmit-side counterpart of shift_register.
- Captures one flat WIDTH*SIZE vector and emits it one WIDTH-bit element per handshake.
- Emission order is oldest slot (MSB) first, newest slot (LSB) last.
- Feeding data_out into shift_register, with shift_signal = out_valid & out_ready, reconstructs the loaded vector in reg_out after SIZE beats.

Parameters:
- WIDTH, 8, bits per element.
- SIZE, 8, elements per vector; must be at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- load_valid  in  1  load_data is valid
- load_ready  out  1  block can accept a vector
- load_data  in  WIDTH*SIZE  vector to transmit; slot k = load_data[WIDTH*(k+1)-1 : WIDTH*k]
- out_valid  out  1  data_out is valid
- out_ready  in  1  sink accepts data_out
- data_out  out  WIDTH  current element
- out_last  out  1  current element is slot 0 (final beat)
- busy  out  1  vector in flight (state is SHIFT)

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, buffer=0, count=0.
  - out_valid=0, data_out=0, out_last=0, busy=0, load_ready=1.
  - Reset has priority over every other event.
- Internal state:
  - buffer, WIDTH*SIZE bits.
  - count, $clog2(SIZE) bits: number of remaining beats minus 1.
- FSM states:
  - IDLE: load_ready=1, out_valid=0. On load_valid: buffer<=load_data, count<=SIZE-1, go to SHIFT.
  - SHIFT: load_ready=0, out_valid=1, busy=1.
    - data_out = buffer[WIDTH*SIZE-1 -: WIDTH].
    - out_last = (count==0).
- Beat acceptance (out_valid & out_ready in SHIFT):
  - buffer <= buffer << WIDTH, zero-filled at the LSB.
  - If count==0, go to IDLE; otherwise count <= count-1.
- Latency: a load accepted at edge N gives out_valid=1 with slot SIZE-1 in the cycle after edge N.
- Minimum SIZE cycles per vector when out_ready is held high.
- Backpressure: while out_valid=1 and out_ready=0, data_out and out_last hold stable, and out_valid never deasserts before acceptance.
- load_valid in SHIFT is ignored (load_ready=0). The source must hold the vector until it sees load_ready=1.
- Default mode (feature off): after the last beat there is one IDLE cycle with out_valid=0 before the next vector can appear.
- data_out reads 0 whenever out_valid=0 (registered zeroing, not X).

Optional Feature:
- Macro: SHIFT_UNLOADER_B2B_EN.
- Defined:
  - In SHIFT, load_ready = out_ready & (count==0).
  - A simultaneous last-beat acceptance and load_valid reloads buffer, sets count=SIZE-1 and stays in SHIFT.
  - Result: zero-bubble back-to-back vectors, SIZE cycles per vector sustained.
- Undefined: behaviour exactly as above, with a one-cycle bubble between vectors.

Decomposition:
- Package shift_pkg:
  - state enum {IDLE, SHIFT}.
  - Localparam helper: CNT_W = $clog2(SIZE).
- One natural sub-module, shift_beat_counter: loadable down-counter with a zero flag, used for count/out_last.
- Everything else stays in shift_unloader.

Test Plan:
- Load 64'h0123456789ABCDEF with out_ready=1:
  - data_out = 01,23,45,67,89,AB,CD,EF on 8 consecutive cycles.
  - out_last=1 only on EF.
  - busy falls the cycle after EF.
- Loopback into shift_register (WIDTH=8, SIZE=8, shift_signal=out_valid&out_ready): after 8 beats, reg_out == 64'h0123456789ABCDEF for 10 random vectors.
- Backpressure: out_ready pattern 1,0,0,1,0,1… on vector 64'hFEDCBA9876543210:
  - data_out holds during stalls.
  - Sequence is exactly FE..10.
  - No duplicate or dropped beat.
- load_valid held high with 64'h1111… during SHIFT of 64'hAAAA…:
  - load_ready=0 throughout.
  - All 8 beats are AA.
  - The 11 vector starts only after the IDLE cycle.
- rst=1 after the 3rd beat:
  - Next cycle out_valid=0, data_out=0, busy=0, load_ready=1.
  - A subsequent load restarts at slot 7.
- With SHIFT_UNLOADER_B2B_EN, two vectors back-to-back and out_ready=1: 16 consecutive valid beats, no gap, out_last on beats 8 and 16.
